// File: rtl/csr_seq_ctrl_pkg.sv
// Shared definitions for the machine-mode CSR sequencing controller.
//   - CSR addresses touched by trap/mret sequencing (plus a few neighbours)
//   - CSR file access-type encodings
//   - sequencer state enum
//   - alignment helper used for MEPC / MTVEC base handling
package csr_seq_ctrl_pkg;

  localparam int CSR_XLEN = 32;

  // Access-type encodings, identical to the CSR file's own definitions.
  localparam logic [1:0] CSR_READ_ONLY = 2'b00;
  localparam logic [1:0] CSR_WRITE     = 2'b01;
  localparam logic [1:0] CSR_SET       = 2'b10;
  localparam logic [1:0] CSR_CLEAR     = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_EPC   = 3'd1,
    ST_T_CAUSE = 3'd2,
    ST_T_VEC   = 3'd3,
    ST_M_EPC   = 3'd4
  } state_e;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/csr_seq_ctrl_if.sv
// Bundle of every non-clock signal around the CSR sequencing controller:
// pipeline CSR request/response, trap and mret handshakes, redirect output
// and the single access port of the CSR file.
//   slave  : the controller itself
//   master : the surrounding pipeline + CSR file
interface csr_seq_ctrl_if;
  import csr_seq_ctrl_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [11:0]           req_number;
  logic [1:0]            req_access_type;
  logic [CSR_XLEN-1:0]   req_wdata;
  logic                  rvalid;
  logic [CSR_XLEN-1:0]   rdata;

  logic                  trap_valid;
  logic                  trap_ready;
  logic [CSR_XLEN-1:0]   trap_cause;
  logic [CSR_XLEN-1:0]   trap_epc;

  logic                  mret_valid;
  logic                  mret_ready;

  logic                  redirect_valid;
  logic [CSR_XLEN-1:0]   redirect_pc;
  logic                  busy;

  logic [11:0]           csr_number;
  logic [1:0]            csr_access_type;
  logic [CSR_XLEN-1:0]   csr_in;
  logic [CSR_XLEN-1:0]   csr_out;

  modport slave (
    input  req_valid, req_number, req_access_type, req_wdata,
    input  trap_valid, trap_cause, trap_epc, mret_valid, csr_out,
    output req_ready, rvalid, rdata, trap_ready, mret_ready,
    output redirect_valid, redirect_pc, busy,
    output csr_number, csr_access_type, csr_in
  );

  modport master (
    output req_valid, req_number, req_access_type, req_wdata,
    output trap_valid, trap_cause, trap_epc, mret_valid, csr_out,
    input  req_ready, rvalid, rdata, trap_ready, mret_ready,
    input  redirect_valid, redirect_pc, busy,
    input  csr_number, csr_access_type, csr_in
  );

endinterface

// File: rtl/csr_seq_ctrl_trap_vector_calc.sv
// Trap target computation from MTVEC and MCAUSE (purely combinational).
//   i_mtvec       : current MTVEC value
//   i_cause       : latched mcause (bit 31 = interrupt)
//   i_vectored_en : allow vectored mode
//   o_target      : fetch target for the trap handler
module trap_vector_calc
  import csr_seq_ctrl_pkg::*;
(
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_cause,
  input  logic        i_vectored_en,
  output logic [31:0] o_target
);

  logic [31:0] w_base;
  logic        w_vectored;

  assign w_base     = align4(i_mtvec);
  // Modes 2 and 3 fall back to direct.
  assign w_vectored = i_vectored_en && (i_mtvec[1:0] == 2'b01) && i_cause[31];
  // Shifting the full cause drops bit 31, leaving cause[30:0]<<2 mod 2^32.
  assign o_target   = w_vectored ? (w_base + (i_cause << 2)) : w_base;

endmodule

// File: rtl/csr_seq_ctrl.sv
// Arbiter/sequencer for the single machine-mode CSR file port.
// Shares the port between pipeline Zicsr requests and trap/mret sequencing,
// and produces the redirect PC for traps and mret.
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : csr_seq_ctrl_if.slave (request, trap, mret, redirect, CSR port)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | accept trap > mret > req; pass req to CSR file
// ST_T_EPC   | write MEPC with aligned trap epc
// ST_T_CAUSE | write MCAUSE with trap cause
// ST_T_VEC   | read MTVEC, compute handler target
// ST_M_EPC   | read MEPC for mret target
module csr_seq_ctrl
  import csr_seq_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  csr_seq_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_cause;
  logic [XLEN-1:0]   r_epc;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_rvalid;
  logic              r_redirect_valid;
  logic [XLEN-1:0]   w_target;

  logic              w_trap_ready;
  logic              w_mret_ready;
  logic              w_req_ready;
  logic              w_req_fire;
  logic              w_trap_fire;
  logic [11:0]       w_csr_number;
  logic [1:0]        w_csr_access_type;
  logic [XLEN-1:0]   w_csr_in;

  trap_vector_calc u_trap_vector_calc (
    .i_mtvec       (bus.csr_out),
    .i_cause       (r_cause),
    .i_vectored_en (VECTORED_EN),
    .o_target      (w_target)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.trap_valid)      w_state_nxt = ST_T_EPC;
        else if (bus.mret_valid) w_state_nxt = ST_M_EPC;
      end
      ST_T_EPC:   w_state_nxt = ST_T_CAUSE;
      ST_T_CAUSE: w_state_nxt = ST_T_VEC;
      ST_T_VEC:   w_state_nxt = ST_IDLE;
      ST_M_EPC:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // While reset is held the port is forced idle so an abandoned sequence
  // cannot commit one more write on the reset edge.
  always_comb begin
    w_trap_ready      = 1'b0;
    w_mret_ready      = 1'b0;
    w_req_ready       = 1'b0;
    w_csr_number      = 12'h000;
    w_csr_access_type = CSR_READ_ONLY;
    w_csr_in          = '0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          w_trap_ready = 1'b1;
          w_mret_ready = !bus.trap_valid;
          w_req_ready  = !bus.trap_valid && !bus.mret_valid;
          if (bus.req_valid && w_req_ready) begin
            w_csr_number      = bus.req_number;
            w_csr_access_type = bus.req_access_type;
            w_csr_in          = bus.req_wdata;
          end
        end
        ST_T_EPC: begin
          w_csr_number      = CSR_MEPC;
          w_csr_access_type = CSR_WRITE;
          w_csr_in          = align4(r_epc);
        end
        ST_T_CAUSE: begin
          w_csr_number      = CSR_MCAUSE;
          w_csr_access_type = CSR_WRITE;
          w_csr_in          = r_cause;
        end
        ST_T_VEC: w_csr_number = CSR_MTVEC;
        ST_M_EPC: w_csr_number = CSR_MEPC;
        default: ;
      endcase
    end
  end

  assign w_req_fire  = bus.req_valid  && w_req_ready;
  assign w_trap_fire = bus.trap_valid && w_trap_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid         <= 1'b0;
      r_rdata          <= '0;
      r_cause          <= '0;
      r_epc            <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_rvalid <= w_req_fire;
      if (w_req_fire) r_rdata <= bus.csr_out;
      if (w_trap_fire) begin
        r_cause <= bus.trap_cause;
        r_epc   <= bus.trap_epc;
      end
      r_redirect_valid <= (r_state == ST_T_VEC) || (r_state == ST_M_EPC);
      if (r_state == ST_T_VEC)      r_redirect_pc <= w_target;
      else if (r_state == ST_M_EPC) r_redirect_pc <= align4(bus.csr_out);
    end
  end

  assign bus.trap_ready      = w_trap_ready;
  assign bus.mret_ready      = w_mret_ready;
  assign bus.req_ready       = w_req_ready;
  assign bus.csr_number      = w_csr_number;
  assign bus.csr_access_type = w_csr_access_type;
  assign bus.csr_in          = w_csr_in;
  assign bus.rvalid          = r_rvalid;
  assign bus.rdata           = r_rdata;
  assign bus.redirect_valid  = r_redirect_valid;
  assign bus.redirect_pc     = r_redirect_pc;
  assign bus.busy            = (r_state != ST_IDLE);

endmodule
